// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the EX stage: a fixed-latency multiplier with
// accumulate modes, and a restoring radix-2 divider. HI/LO change only when an operation completes.
//
// state | meaning
// IDLE  | ready; mthi/mtlo write here, start launches here
// MUL   | multiply in flight; commits at cnt=0
// DIV   | one restoring quotient bit per cycle
// FIX   | apply signs / special cases, commit
module mdu_iter #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       mdu_ctrl,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             start,
  input  logic             Req,
  output logic             busy,
  output logic [WIDTH-1:0] HIorLO
);

  localparam int CNT_MAX = (WIDTH > MULT_LAT) ? WIDTH - 1 : MULT_LAT - 1;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MUL_INIT = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_INIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [3:0] OP_MFHI  = 4'd1;
  localparam logic [3:0] OP_MFLO  = 4'd2;
  localparam logic [3:0] OP_MTHI  = 4'd3;
  localparam logic [3:0] OP_MTLO  = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_MULTU = 4'd6;
  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_DIVU  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_rem;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic               r_ovf;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  // Multiplier datapath: operands were latched at launch, result commits at cnt=0.
  logic                 w_mul_sgn;
  logic                 w_mul_acc;
  logic                 w_mul_sub;
  logic [2*WIDTH-1:0]   w_ext_a;
  logic [2*WIDTH-1:0]   w_ext_b;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_mul_res;

  always_comb begin
    w_mul_sgn = (r_op == OP_MULT) || (r_op == OP_MADD) || (r_op == OP_MSUB);
    w_mul_acc = (r_op == OP_MADD) || (r_op == OP_MADDU) || (r_op == OP_MSUB) || (r_op == OP_MSUBU);
    w_mul_sub = (r_op == OP_MSUB) || (r_op == OP_MSUBU);
    w_ext_a   = w_mul_sgn ? {{WIDTH{r_opa[WIDTH-1]}}, r_opa} : {{WIDTH{1'b0}}, r_opa};
    w_ext_b   = w_mul_sgn ? {{WIDTH{r_opb[WIDTH-1]}}, r_opb} : {{WIDTH{1'b0}}, r_opb};
    w_prod    = w_ext_a * w_ext_b;
    w_mul_res = w_prod;
    if (w_mul_acc) begin
      w_mul_res = w_mul_sub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
    end
  end

  // Divider launch: magnitudes and signs of the incoming operands.
  logic             w_div_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  always_comb begin
    w_div_sgn = (mdu_ctrl == OP_DIV);
    w_a_neg   = w_div_sgn & inA[WIDTH-1];
    w_b_neg   = w_div_sgn & inB[WIDTH-1];
    w_a_mag   = w_a_neg ? (-inA) : inA;
    w_b_mag   = w_b_neg ? (-inB) : inB;
  end

  // One restoring step: shift the next dividend bit into the partial remainder.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_q_nx;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  always_comb begin
    w_shift  = {r_rem, r_q[WIDTH-1]};
    w_diff   = w_shift - {1'b0, r_opb};
    w_ge     = w_shift[WIDTH] | ~w_diff[WIDTH];
    w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_q_nx   = {r_q[WIDTH-2:0], w_ge};
    w_q_fix  = r_neg_q ? (-r_q) : r_q;
    w_r_fix  = r_neg_r ? (-r_rem) : r_rem;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_op    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (Req) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mdu_ctrl == OP_MTHI) r_hi <= inA;
          if (mdu_ctrl == OP_MTLO) r_lo <= inA;
          if (start && is_mul(mdu_ctrl)) begin
            r_op    <= mdu_ctrl;
            r_opa   <= inA;
            r_opb   <= inB;
            r_cnt   <= MUL_INIT;
            r_state <= S_MUL;
            r_busy  <= 1'b1;
          end else if (start && ((mdu_ctrl == OP_DIV) || (mdu_ctrl == OP_DIVU))) begin
            r_op    <= mdu_ctrl;
            r_opa   <= inA;
            r_opb   <= w_b_mag;
            r_q     <= w_a_mag;
            r_rem   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= (inB == '0);
            r_ovf   <= w_div_sgn && (inA == MIN_VAL) && (inB == '1);
            r_cnt   <= DIV_INIT;
            r_state <= S_DIV;
            r_busy  <= 1'b1;
          end
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            {r_hi, r_lo} <= w_mul_res;
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nx;
          r_q   <= w_q_nx;
          if (r_cnt == '0) r_state <= S_FIX;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        S_FIX: begin
          if (r_dz) begin
            r_lo <= '1;
            r_hi <= r_opa;
          end else if (r_ovf) begin
            r_lo <= MIN_VAL;
            r_hi <= '0;
          end else begin
            r_lo <= w_q_fix;
            r_hi <= w_r_fix;
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    HIorLO = '0;
    if (mdu_ctrl == OP_MFHI)      HIorLO = r_hi;
    else if (mdu_ctrl == OP_MFLO) HIorLO = r_lo;
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, randomized ops against an
// arithmetic reference model, and hand sequences for abort/ignore/reset corner cases.
module tb_mdu_iter;
  localparam int W = 32;
  localparam int L = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   mdu_ctrl = '0;
  logic [W-1:0] inA = '0;
  logic [W-1:0] inB = '0;
  logic         start = 1'b0;
  logic         Req = 1'b0;
  logic         busy;
  logic [W-1:0] HIorLO;

  int errors = 0;
  int checks = 0;

  mdu_iter #(.WIDTH(W), .MULT_LAT(L)) dut (
    .clk(clk), .reset(reset), .mdu_ctrl(mdu_ctrl), .inA(inA), .inB(inB),
    .start(start), .Req(Req), .busy(busy), .HIorLO(HIorLO)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] pre;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hl(output logic [W-1:0] hi, output logic [W-1:0] lo);
    mdu_ctrl = 4'd1;
    #1 hi = HIorLO;
    mdu_ctrl = 4'd2;
    #1 lo = HIorLO;
    mdu_ctrl = 4'd0;
  endtask

  task automatic set_hl(input logic [63:0] v);
    mdu_ctrl = 4'd3; inA = v[63:32];
    tick();
    mdu_ctrl = 4'd4; inA = v[31:0];
    tick();
    mdu_ctrl = 4'd0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    mdu_ctrl = op; inA = a; inB = b; start = 1'b1;
    tick();
    start = 1'b0; mdu_ctrl = 4'd0;
    lat = 0;
    while (busy && lat < 200) begin
      lat++;
      tick();
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definition of each op.
  function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
    logic [63:0] p;
    longint      sp;
    int          sa, sb;
    logic [31:0] q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (op == 4'd5 || op == 4'd9 || op == 4'd11) begin
      sp = longint'(sa) * longint'(sb);
      p  = 64'(sp);
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
    case (op)
      4'd5, 4'd6:   return p;
      4'd9, 4'd10:  return acc + p;
      4'd11, 4'd12: return acc - p;
      4'd7: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
      4'd8: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return acc;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    return (op == 4'd7 || op == 4'd8) ? W + 1 : L;
  endfunction

  initial begin
    logic [W-1:0] hi, lo;
    logic [63:0]  pre, exp;
    logic [3:0]   op;
    logic [31:0]  a, b;
    int           lat;

    vecs[0]  = '{4'd5,  32'hFFFF_FFFF, 32'd2,         64'd0,  64'hFFFF_FFFF_FFFF_FFFE, L};
    vecs[1]  = '{4'd6,  32'hFFFF_FFFF, 32'd2,         64'd0,  64'h0000_0001_FFFF_FFFE, L};
    vecs[2]  = '{4'd7,  32'hFFFF_FFF9, 32'd2,         64'd0,  64'hFFFF_FFFF_FFFF_FFFD, W + 1};
    vecs[3]  = '{4'd8,  32'd7,         32'd0,         64'd0,  64'h0000_0007_FFFF_FFFF, W + 1};
    vecs[4]  = '{4'd7,  32'h8000_0000, 32'hFFFF_FFFF, 64'd5,  64'h0000_0000_8000_0000, W + 1};
    vecs[5]  = '{4'd9,  32'd3,         32'd4,         64'd10, 64'd22,                  L};
    vecs[6]  = '{4'd12, 32'd5,         32'd5,         64'd22, 64'hFFFF_FFFF_FFFF_FFFD, L};
    vecs[7]  = '{4'd7,  32'd7,         32'd0,         64'd0,  64'h0000_0007_FFFF_FFFF, W + 1};
    vecs[8]  = '{4'd8,  32'd100,       32'd7,         64'd0,  64'h0000_0002_0000_000E, W + 1};
    vecs[9]  = '{4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1,  64'hFFFF_FFFE_0000_0002, L};
    vecs[10] = '{4'd11, 32'hFFFF_FFFF, 32'd1,         64'd0,  64'd1,                   L};
    vecs[11] = '{4'd7,  32'd7,         32'hFFFF_FFFE, 64'd0,  64'h0000_0001_FFFF_FFFD, W + 1};

    // Reset state and mthi/mfhi
    #3 reset = 1'b0;
    #10;
    check("reset_busy", 64'(busy), 64'd0);
    read_hl(hi, lo);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    tick();
    mdu_ctrl = 4'd3; inA = 32'h1234_5678;
    tick();
    mdu_ctrl = 4'd0;
    read_hl(hi, lo);
    check("mthi_mfhi", 64'(hi), 64'h1234_5678);

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      set_hl(vecs[i].pre);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      read_hl(hi, lo);
      check($sformatf("vec%0d_hilo", i), {hi, lo}, vecs[i].exp);
    end

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      op  = 4'($urandom_range(5, 12));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000; b = 32'hFFFF_FFFF;
      end
      pre = {$urandom, $urandom};
      exp = ref_op(op, a, b, pre);
      set_hl(pre);
      run_op(op, a, b, lat);
      check($sformatf("rnd%0d_op%0d_lat", i, op), 64'(lat), 64'(ref_lat(op)));
      read_hl(hi, lo);
      check($sformatf("rnd%0d_op%0d_hilo", i, op), {hi, lo}, exp);
    end

    // Req aborts an in-flight divide with no effect on HI/LO
    set_hl(64'hAAAA_0000_0000_5555);
    mdu_ctrl = 4'd7; inA = 32'd100; inB = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; mdu_ctrl = 4'd0;
    repeat (9) tick();
    check("abort_busy_before", 64'(busy), 64'd1);
    Req = 1'b1;
    tick();
    Req = 1'b0;
    check("abort_busy_after", 64'(busy), 64'd0);
    repeat (40) tick();
    check("abort_busy_later", 64'(busy), 64'd0);
    read_hl(hi, lo);
    check("abort_hilo", {hi, lo}, 64'hAAAA_0000_0000_5555);

    // start and Req together: no launch; mthi with Req: no write
    mdu_ctrl = 4'd5; inA = 32'd3; inB = 32'd3; start = 1'b1; Req = 1'b1;
    tick();
    start = 1'b0; Req = 1'b0; mdu_ctrl = 4'd0;
    check("startreq_busy", 64'(busy), 64'd0);
    repeat (8) tick();
    mdu_ctrl = 4'd3; inA = 32'hDEAD_BEEF; Req = 1'b1;
    tick();
    Req = 1'b0; mdu_ctrl = 4'd0;
    read_hl(hi, lo);
    check("startreq_mtreq_hilo", {hi, lo}, 64'hAAAA_0000_0000_5555);

    // mfhi during a mult returns old HI; mthi and a new start while busy are ignored
    set_hl(64'h1111_2222_3333_4444);
    mdu_ctrl = 4'd5; inA = 32'd6; inB = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; mdu_ctrl = 4'd0;
    lat = 0;
    while (busy && lat < 200) begin
      lat++;
      if (lat == 1) begin
        mdu_ctrl = 4'd1;
        #1 check("mfhi_while_busy", 64'(HIorLO), 64'h1111_2222);
        mdu_ctrl = 4'd3; inA = 32'h0BAD_0BAD;
      end
      if (lat == 2) begin
        mdu_ctrl = 4'd7; inA = 32'd100; inB = 32'd0; start = 1'b1;
      end
      if (lat == 3) begin
        start = 1'b0; mdu_ctrl = 4'd0;
      end
      tick();
    end
    check("ignore_start_lat", 64'(lat), 64'(L));
    repeat (3) tick();
    check("ignore_start_idle", 64'(busy), 64'd0);
    read_hl(hi, lo);
    check("ignore_start_hilo", {hi, lo}, 64'd42);

    // Reset mid-division clears everything without commit
    set_hl(64'h0000_0001_0000_0002);
    mdu_ctrl = 4'd7; inA = 32'd100; inB = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; mdu_ctrl = 4'd0;
    repeat (5) tick();
    reset = 1'b0;
    #1 check("midreset_busy", 64'(busy), 64'd0);
    read_hl(hi, lo);
    check("midreset_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    repeat (40) tick();
    check("midreset_busy_later", 64'(busy), 64'd0);
    read_hl(hi, lo);
    check("midreset_hilo_later", {hi, lo}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
